// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : MIPS32 instruction-fetch stage. Owns the PC and the IF/ID
//               register and fetches over a single-outstanding imem handshake.
//               Redirects and memory wait states insert NOP bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFID_Write,
  input  logic        Branched,
  input  logic [31:0] branch_target,
  input  logic        Jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_PC_plus4,
  output logic        IF_ID_valid,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HAVE = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state, w_stateNext;
  logic [31:0] r_pc, w_pcNext;
  logic [31:0] r_ifInstr, w_instrNext;
  logic [31:0] r_ifPc4, w_pc4Next;
  logic        r_ifValid, w_validNext;
  logic [31:0] r_hold, w_holdNext;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_available;
  logic        w_inFlight;
  logic [31:0] w_instr;
  logic [31:0] w_pcPlus4;

  // Redirect decode and instruction availability; the branch is older than the jump so it wins
  always_comb begin
    w_redirect  = Branched | Jump;
    w_target    = Branched ? branch_target : {r_ifPc4[31:28], jump_index, 2'b00};
    w_available = ((r_state == S_REQ) & imem_ready & imem_rvalid) |
                  ((r_state == S_WAIT) & imem_rvalid) |
                  (r_state == S_HAVE);
    // A request accepted with no response yet still owes one beat that must be dropped
    w_inFlight  = ((r_state == S_WAIT) & ~imem_rvalid) |
                  ((r_state == S_REQ) & imem_ready & ~imem_rvalid);
    w_instr     = (r_state == S_HAVE) ? r_hold : imem_rdata;
    w_pcPlus4   = r_pc + 32'd4;
  end

  // Next-state, PC and IF/ID update selection
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_instrNext = r_ifInstr;
    w_pc4Next   = r_ifPc4;
    w_validNext = r_ifValid;
    w_holdNext  = r_hold;
    if (w_redirect) begin
      w_pcNext    = w_target;
      w_instrNext = 32'h0;
      w_validNext = 1'b0;
      if (w_inFlight) begin
        w_stateNext = S_DROP;
      end else if ((r_state == S_DROP) && !imem_rvalid) begin
        // The owed response has not arrived yet, keep waiting to discard it
        w_stateNext = S_DROP;
      end else begin
        w_stateNext = S_REQ;
      end
    end else if (r_state == S_DROP) begin
      if (imem_rvalid) begin
        w_stateNext = S_REQ;
      end
      if (IFID_Write) begin
        w_instrNext = 32'h0;
        w_validNext = 1'b0;
      end
    end else if (w_available) begin
      if (IFID_Write) begin
        w_instrNext = w_instr;
        w_pc4Next   = w_pcPlus4;
        w_validNext = 1'b1;
        if (PCWrite) begin
          w_pcNext = w_pcPlus4;
        end
        w_stateNext = S_REQ;
      end else begin
        if (r_state != S_HAVE) begin
          w_holdNext = imem_rdata;
        end
        w_stateNext = S_HAVE;
      end
    end else begin
      if ((r_state == S_REQ) && imem_ready) begin
        w_stateNext = S_WAIT;
      end
      if (IFID_Write) begin
        w_instrNext = 32'h0;
        w_validNext = 1'b0;
      end
    end
  end

  // State, PC, hold and IF/ID registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_ifInstr <= 32'h0;
      r_ifPc4   <= 32'h0;
      r_ifValid <= 1'b0;
      r_hold    <= 32'h0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_ifInstr <= w_instrNext;
      r_ifPc4   <= w_pc4Next;
      r_ifValid <= w_validNext;
      r_hold    <= w_holdNext;
    end
  end

  assign imem_req       = (r_state == S_REQ);
  assign imem_addr      = r_pc;
  assign IF_ID_instr    = r_ifInstr;
  assign IF_ID_PC_plus4 = r_ifPc4;
  assign IF_ID_valid    = r_ifValid;
  assign fetch_stall    = ~w_available & ~w_redirect;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage with a scoreboard
//               of expected IF/ID deliveries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        PCWrite, IFID_Write, Branched, Jump;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_ID_instr, IF_ID_PC_plus4;
  logic        IF_ID_valid, fetch_stall;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sbQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  if_stage #(.RESET_PC(32'h0000_0400)) dut (
    .clock(clock), .reset(reset),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write),
    .Branched(Branched), .branch_target(branch_target),
    .Jump(Jump), .jump_index(jump_index),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_instr(IF_ID_instr), .IF_ID_PC_plus4(IF_ID_PC_plus4),
    .IF_ID_valid(IF_ID_valid), .fetch_stall(fetch_stall)
  );

  always #5 clock = ~clock;

  // Instruction image: a distinct nonzero word per address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], 16'h1234} ^ 32'h5A00_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic void push(input logic [31:0] a);
    exp_t e;
    e.instr = memWord(a);
    e.pc4   = a + 32'd4;
    sbQ.push_back(e);
  endfunction

  // Advance one clock; if a new delivery is due, pop and compare it
  task automatic cyc(input bit newDeliv);
    exp_t e;
    @(posedge clock);
    #1;
    if (newDeliv) begin
      check("sb_nonempty", {31'd0, sbQ.size() > 0}, 32'd1);
      check("deliv_valid", {31'd0, IF_ID_valid}, 32'd1);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        check("deliv_instr", IF_ID_instr, e.instr);
        check("deliv_pc4", IF_ID_PC_plus4, e.pc4);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1; PCWrite = 1'b1; IFID_Write = 1'b1;
    Branched = 1'b0; Jump = 1'b0; branch_target = '0; jump_index = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    #12;
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'h400);
    check("rst_instr", IF_ID_instr, 32'h0);
    check("rst_pc4", IF_ID_PC_plus4, 32'h0);
    check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    check("rst_stall", {31'd0, fetch_stall}, 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;

    // Zero-latency memory: one instruction per cycle
    imem_ready = 1'b1; imem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h400 + 32'(4 * i);
      imem_rdata = memWord(a);
      #1;
      check("zl_addr", imem_addr, a);
      check("zl_req", {31'd0, imem_req}, 32'd1);
      check("zl_stall", {31'd0, fetch_stall}, 32'd0);
      push(a);
      cyc(1);
    end

    // Response two cycles after acceptance: valid pattern 0,0,1
    for (int i = 0; i < 2; i++) begin
      a = 32'h40C + 32'(4 * i);
      imem_ready = 1'b1; imem_rvalid = 1'b0; #1;
      check("lat_addr", imem_addr, a);
      check("lat_stall0", {31'd0, fetch_stall}, 32'd1);
      cyc(0);
      check("lat_valid0", {31'd0, IF_ID_valid}, 32'd0);
      imem_ready = 1'b0; #1;
      check("lat_req_wait", {31'd0, imem_req}, 32'd0);
      check("lat_stall1", {31'd0, fetch_stall}, 32'd1);
      cyc(0);
      check("lat_valid1", {31'd0, IF_ID_valid}, 32'd0);
      imem_rvalid = 1'b1; imem_rdata = memWord(a); #1;
      check("lat_stall2", {31'd0, fetch_stall}, 32'd0);
      push(a);
      cyc(1);
    end

    // Load-use stall while the response arrives: buffered, then delivered
    imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = memWord(32'h414);
    PCWrite = 1'b0; IFID_Write = 1'b0;
    cyc(0);
    check("stall_hold_pc4", IF_ID_PC_plus4, 32'h414);
    check("stall_hold_valid", {31'd0, IF_ID_valid}, 32'd1);
    check("stall_hold_addr", imem_addr, 32'h414);
    check("stall_have_req", {31'd0, imem_req}, 32'd0);
    PCWrite = 1'b1; IFID_Write = 1'b1;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0BAD_0BAD; #1;
    check("have_stall", {31'd0, fetch_stall}, 32'd0);
    push(32'h414);
    cyc(1);
    check("have_next_addr", imem_addr, 32'h418);

    // Branch to 0x0040000C (nothing in flight), then fetch it
    Branched = 1'b1; branch_target = 32'h0040_000C; #1;
    check("br_stall", {31'd0, fetch_stall}, 32'd0);
    cyc(0);
    Branched = 1'b0;
    check("br_bubble_instr", IF_ID_instr, 32'h0);
    check("br_bubble_valid", {31'd0, IF_ID_valid}, 32'd0);
    check("br_addr", imem_addr, 32'h0040_000C);
    check("br_req", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = memWord(32'h0040_000C);
    push(32'h0040_000C);
    cyc(1);

    // Jump: target from IF_ID_PC_plus4[31:28]; available word is discarded
    Jump = 1'b1; jump_index = 26'h000_0100; imem_rdata = 32'hCAFE_F00D;
    cyc(0);
    Jump = 1'b0;
    check("j_addr", imem_addr, 32'h0000_0400);
    check("j_instr", IF_ID_instr, 32'h0);
    check("j_valid", {31'd0, IF_ID_valid}, 32'd0);
    check("j_pc4_kept", IF_ID_PC_plus4, 32'h0040_0010);

    // Branch while awaiting a response: the late response must be dropped
    imem_ready = 1'b1; imem_rvalid = 1'b0;
    cyc(0);
    imem_ready = 1'b0;
    Branched = 1'b1; branch_target = 32'h500;
    cyc(0);
    Branched = 1'b0;
    check("drop_addr", imem_addr, 32'h500);
    check("drop_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check("drop_stall", {31'd0, fetch_stall}, 32'd1);
    cyc(0);
    check("drop_instr", IF_ID_instr, 32'h0);
    check("drop_valid", {31'd0, IF_ID_valid}, 32'd0);
    check("drop_req_after", {31'd0, imem_req}, 32'd1);
    check("drop_addr_after", imem_addr, 32'h500);
    imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = memWord(32'h500);
    push(32'h500);
    cyc(1);

    // Branch and jump together: branch wins
    imem_ready = 1'b0; imem_rvalid = 1'b0;
    Branched = 1'b1; Jump = 1'b1; branch_target = 32'hFFFF_FFFC; jump_index = 26'h3FF_FFFF;
    cyc(0);
    Branched = 1'b0; Jump = 1'b0;
    check("prio_addr", imem_addr, 32'hFFFF_FFFC);

    // PC+4 wraps to zero
    imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = memWord(32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    cyc(1);
    check("wrap_addr", imem_addr, 32'h0);

    // Deliver one, then accept with IF/ID held and reset mid-wait
    imem_rdata = memWord(32'h0);
    push(32'h0);
    cyc(1);
    imem_rvalid = 1'b0; IFID_Write = 1'b0;
    cyc(0);
    check("rw_req_wait", {31'd0, imem_req}, 32'd0);
    check("rw_valid_held", {31'd0, IF_ID_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd1);
    check("arst_addr", imem_addr, 32'h400);
    check("arst_instr", IF_ID_instr, 32'h0);
    check("arst_pc4", IF_ID_PC_plus4, 32'h0);
    check("arst_valid", {31'd0, IF_ID_valid}, 32'd0);
    #2;
    reset = 1'b0;

    check("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS32 pipeline. It owns the PC and the IF/ID pipeline register, and talks to instruction memory over a single-outstanding request/response handshake. It sits directly upstream of ID (`control_main`, `Hazard_Unit`) and consumes their `PCWrite`, `IFID_Write`, `Jump` and `Branched` outputs. It delivers `IF_ID_instr` and `IF_ID_PC_plus4` to ID and inserts NOP bubbles on redirects and memory wait states.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `PCWrite`  in  1: PC advance enable (0 during load-use stall).
- `IFID_Write`  in  1: IF/ID load enable (0 = hold).
- `Branched`  in  1: taken branch resolved; redirect to `branch_target`.
- `branch_target`  in  32: branch destination.
- `Jump`  in  1: J decoded in ID; redirect to jump target.
- `jump_index`  in  26: instr[25:0] of the J in ID.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: fetch address (= PC).
- `imem_ready`  in  1: request accepted this cycle.
- `imem_rvalid`  in  1: response data valid.
- `imem_rdata`  in  32: response instruction.
- `IF_ID_instr`  out  32: instruction to ID; 32'h0 is a bubble (`sll r0,r0,0`).
- `IF_ID_PC_plus4`  out  32: PC+4 of `IF_ID_instr`.
- `IF_ID_valid`  out  1: IF/ID holds a real instruction.
- `fetch_stall`  out  1: no instruction is available this cycle.

## Operation
- FSM states:
  - S_REQ: request pending.
  - S_WAIT: accepted, awaiting response.
  - S_HAVE: response buffered in the hold register.
  - S_DROP: a response is owed for a squashed fetch.
- `imem_req` = (state == S_REQ); `imem_addr` = PC.
- Instruction *available* in a cycle when any of these holds:
  - S_REQ & `imem_ready` & `imem_rvalid` (zero-latency memory).
  - S_WAIT & `imem_rvalid`.
  - S_HAVE (hold register).
- S_REQ with `imem_ready` & !`imem_rvalid` → S_WAIT. With !`imem_ready` → stay.
- Redirect = `Branched` | `Jump`.
  - `Branched` has priority (older instruction). Target = `branch_target`.
  - Jump target = {`IF_ID_PC_plus4`[31:28], `jump_index`, 2'b00}.
- On a redirect cycle, regardless of `PCWrite`/`IFID_Write`:
  - PC ← target.
  - IF/ID ← bubble (instr=0, valid=0, PC_plus4 unchanged).
  - Any available instruction is discarded.
  - Next state:
    - S_DROP if a request is in flight with no response yet: S_WAIT & !rvalid, or S_REQ & ready & !rvalid.
    - S_REQ otherwise.
- S_DROP:
  - The next `imem_rvalid` is ignored → S_REQ.
  - A further redirect in S_DROP updates PC and stays in S_DROP.
  - If IFID_Write=1, IF/ID ← bubble.
- No redirect, instruction available, `IFID_Write`=1 → *deliver*:
  - IF_ID_instr ← instr; IF_ID_PC_plus4 ← PC+4; IF_ID_valid ← 1.
  - PC ← PC+4 if `PCWrite`.
  - Next state S_REQ.
- No redirect, instruction available, `IFID_Write`=0:
  - Hold register captures rvalid data (if not already in S_HAVE) → S_HAVE.
  - IF/ID and PC hold.
- No redirect, no instruction, `IFID_Write`=1 → IF/ID ← bubble.
- `fetch_stall` = !available & !redirect (combinational).
- PC+4 wraps modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.

## Timing
- Reset (async, immediate):
  - PC=RESET_PC, state=S_REQ.
  - IF_ID_instr=0, IF_ID_PC_plus4=0, IF_ID_valid=0.
  - Hold register=0.
  - Hence `imem_req`=1, `imem_addr`=RESET_PC, `fetch_stall`=1 unless memory responds.
- Reset mid-fetch drops any in-flight request. Instruction memory shares `reset`, so no stale response follows.
- Zero-latency memory: one instruction per cycle. rvalid N cycles after acceptance: one instruction per N+1 cycles.
- Delivery latency: IF/ID updates on the clock edge ending the cycle in which the instruction became available.
- Redirect penalty:
  - Jump: 1 bubble.
  - Branch: the bubble inserted that cycle, plus any outstanding drop.
- Only one request is ever outstanding. `imem_req` stays low in S_WAIT, S_HAVE and S_DROP.

## Test plan
- Reset, RESET_PC=0x400, memory ready=1 with same-cycle rvalid, IFID_Write=PCWrite=1 → `imem_addr` 0x400, 0x404, 0x408 on consecutive cycles; IF_ID_PC_plus4 0x404, 0x408, 0x40C; valid=1 each cycle.
- rvalid 2 cycles after acceptance → IF_ID_valid pattern 0,0,1 repeating; `fetch_stall`=1 in both wait cycles; `imem_req` low during S_WAIT.
- Load-use stall: PCWrite=IFID_Write=0 for 1 cycle while rvalid arrives → IF/ID and PC hold, state S_HAVE; next cycle the buffered instruction is delivered, PC+4.
- Jump with IF_ID_PC_plus4=0x0040_0010, jump_index=0x0000100 → PC=0x0000_0400 next cycle; IF/ID bubble (instr 0, valid 0).
- Branched=1 (target 0x500) while in S_WAIT, rvalid one cycle later with data 0xDEADBEEF → 0xDEADBEEF never reaches IF/ID; the next request address is 0x500.
- Branched and Jump asserted together → PC=branch_target. Async reset asserted mid-S_WAIT → outputs return to reset values immediately.
